// File: rtl/iterative_muldiv_sequencer.sv
// Iterative MUL/DIVU/REMU sequencer that borrows the shared execute ALU,
// retiring one bit of the result per cycle.
package HighLevelControl;
    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1
    } aluOperation;
endpackage

module iterative_muldiv_sequencer #(
    parameter int BIT_COUNT = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          InValid,
    output logic                          InReady,
    input  logic [1:0]                    Op,
    input  logic [BIT_COUNT-1:0]          OpA,
    input  logic [BIT_COUNT-1:0]          OpB,
    output logic                          OutValid,
    input  logic                          OutReady,
    output logic [BIT_COUNT-1:0]          Result,
    output logic                          AluBusy,
    output HighLevelControl::aluOperation AluOp,
    output logic [BIT_COUNT-1:0]          AluOpA,
    output logic [BIT_COUNT-1:0]          AluOpB,
    input  logic [BIT_COUNT-1:0]          AluResult,
    input  logic                          AluCarry
);
    import HighLevelControl::*;

    localparam int W  = BIT_COUNT;
    localparam int CW = $clog2(BIT_COUNT);
    localparam logic [CW-1:0] LAST = CW'(BIT_COUNT - 1);

    // LOAD is a one-cycle staging state between accept and RUN/DONE
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REMU = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    logic [1:0]    state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  mcand_q, mcand_d;
    logic [W-1:0]  mplier_q, mplier_d;
    logic [W-1:0]  result_q, result_d;
    logic          special_q, special_d;

    logic [W-1:0]  t;
    logic          take;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        result_d  = result_q;
        special_d = special_q;
        AluOp     = ADD;
        AluOpA    = '0;
        AluOpB    = '0;
        t         = {acc_q[W-2:0], mplier_q[W-1]};
        // a set remainder MSB means the true shifted value exceeds any divisor
        take      = ~AluCarry | acc_q[W-1];

        unique case (state_q)
            S_IDLE: begin
                if (InValid) begin
                    op_d      = Op;
                    acc_d     = '0;
                    cnt_d     = '0;
                    mcand_d   = OpB;
                    mplier_d  = OpA;
                    special_d = 1'b1;
                    state_d   = S_LOAD;
                    if (Op == OP_RSVD) begin
                        result_d = '0;
                    end else if (Op != OP_MUL && OpB == '0) begin
                        result_d = (Op == OP_DIVU) ? '1 : OpA;
                    end else begin
                        special_d = 1'b0;
                    end
                end
            end
            S_LOAD: begin
                state_d = special_q ? S_DONE : S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (op_q == OP_MUL) begin
                    AluOp    = ADD;
                    AluOpA   = acc_q;
                    AluOpB   = mcand_q;
                    if (mplier_q[0]) acc_d = AluResult;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end else begin
                    AluOp    = SUB;
                    AluOpA   = t;
                    AluOpB   = mcand_q;
                    acc_d    = take ? AluResult : t;
                    mplier_d = {mplier_q[W-2:0], take};
                end
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    if (op_q == OP_DIVU) result_d = mplier_d;
                    else                 result_d = acc_d;
                end
            end
            S_DONE: begin
                if (OutReady) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= OP_MUL;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            result_q  <= '0;
            special_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            result_q  <= result_d;
            special_q <= special_d;
        end
    end

    assign InReady  = (state_q == S_IDLE);
    assign OutValid = (state_q == S_DONE);
    assign AluBusy  = (state_q == S_RUN);
    assign Result   = result_q;

    logic unused_ok;
    assign unused_ok = ^{OP_REMU};
endmodule

// File: tb/tb_iterative_muldiv_sequencer.sv
// Self-checking bench for iterative_muldiv_sequencer: directed cases
// plus randomized ops against an arithmetic reference model.
module tb_iterative_muldiv_sequencer;
    import HighLevelControl::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         InValid;
    logic         InReady;
    logic [1:0]   Op;
    logic [W-1:0] OpA, OpB;
    logic         OutValid;
    logic         OutReady;
    logic [W-1:0] Result;
    logic         AluBusy;
    aluOperation  AluOp;
    logic [W-1:0] AluOpA, AluOpB;
    logic [W-1:0] AluResult;
    logic         AluCarry;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    iterative_muldiv_sequencer #(.BIT_COUNT(W)) dut (
        .clk(clk), .reset(reset),
        .InValid(InValid), .InReady(InReady),
        .Op(Op), .OpA(OpA), .OpB(OpB),
        .OutValid(OutValid), .OutReady(OutReady),
        .Result(Result), .AluBusy(AluBusy),
        .AluOp(AluOp), .AluOpA(AluOpA), .AluOpB(AluOpB),
        .AluResult(AluResult), .AluCarry(AluCarry)
    );

    // shared combinational ALU; SUB carry = borrow
    always_comb begin
        if (AluOp == SUB)
            {AluCarry, AluResult} = {1'b0, AluOpA} - {1'b0, AluOpB};
        else
            {AluCarry, AluResult} = {1'b0, AluOpA} + {1'b0, AluOpB};
    end

    function automatic logic [W-1:0] model(input logic [1:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (op)
            2'b00:   return p[W-1:0];
            2'b01:   return (b == 0) ? {W{1'b1}} : a / b;
            2'b10:   return (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit early,
                         output logic [W-1:0] res, output int lat,
                         output int busy, output int spur);
        @(negedge clk);
        InValid = 1'b1; Op = op; OpA = a; OpB = b; OutReady = early;
        @(posedge clk); #1;
        InValid = 1'b0; Op = 2'($urandom); OpA = $urandom; OpB = $urandom;
        lat = 0; busy = 0; spur = 0;
        while (!OutValid && lat < 100) begin
            if (AluBusy) busy++;
            else if (AluOp !== ADD || AluOpA !== '0 || AluOpB !== '0) spur++;
            @(posedge clk); #1;
            lat++;
        end
        res = Result;
        if (!early) begin
            @(negedge clk);
            OutReady = 1'b1;
        end
        @(posedge clk); #1;
        OutReady = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; InValid = 1'b1; Op = 2'b00; OpA = 5; OpB = 7;
        OutReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (InReady !== 1'b1) begin fails++;
            $display("FAIL reset_inready got %b want 1", InReady); end
        checks++; if (OutValid !== 1'b0) begin fails++;
            $display("FAIL reset_outvalid got %b want 0", OutValid); end
        checks++; if (Result !== '0) begin fails++;
            $display("FAIL reset_result got %h want 0", Result); end
        checks++; if (AluBusy !== 1'b0) begin fails++;
            $display("FAIL reset_alubusy got %b want 0", AluBusy); end
        checks++;
        if (AluOp !== ADD || AluOpA !== '0 || AluOpB !== '0) begin fails++;
            $display("FAIL reset_alu got op=%0d a=%h b=%h want ADD 0 0",
                     AluOp, AluOpA, AluOpB); end
        @(negedge clk);
        InValid = 1'b0; OutReady = 1'b0; reset = 1'b0;
    endtask

    task automatic test_mul_basic();
        logic [W-1:0] r; int lat, busy, spur;
        do_op(2'b00, 7, 6, 1'b0, r, lat, busy, spur);
        checks++; if (r !== 42) begin fails++;
            $display("FAIL mul7x6 got %0d want 42", r); end
        checks++; if (lat !== 33) begin fails++;
            $display("FAIL mul7x6_latency got %0d want 33", lat); end
        checks++; if (busy !== 32) begin fails++;
            $display("FAIL mul7x6_busy got %0d want 32", busy); end
        checks++; if (spur !== 0) begin fails++;
            $display("FAIL mul7x6_idle_alu got %0d want 0", spur); end
    endtask

    task automatic test_mul_wrap();
        logic [W-1:0] r; int lat, busy, spur;
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, r, lat, busy, spur);
        checks++; if (r !== 32'h1) begin fails++;
            $display("FAIL mul_wrap got %h want 00000001", r); end
        do_op(2'b00, 32'h0001_0000, 32'h0001_0000, 1'b0, r, lat, busy, spur);
        checks++; if (r !== 32'h0) begin fails++;
            $display("FAIL mul_wrap2 got %h want 0", r); end
    endtask

    task automatic test_divrem();
        logic [1:0]   ops [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [W-1:0] as  [4] = '{100, 100, 5, 5};
        logic [W-1:0] bs  [4] = '{7, 7, 9, 9};
        logic [W-1:0] ex  [4] = '{14, 2, 0, 5};
        logic [W-1:0] r; int lat, busy, spur;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], as[i], bs[i], 1'b0, r, lat, busy, spur);
            checks++; if (r !== ex[i] || lat !== 33) begin fails++;
                $display("FAIL divrem[%0d] got %0d lat %0d want %0d lat 33",
                         i, r, lat, ex[i]); end
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] r; int lat, busy, spur;
        do_op(2'b01, 32'h1234, 0, 1'b0, r, lat, busy, spur);
        checks++; if (r !== 32'hFFFF_FFFF || lat !== 1) begin fails++;
            $display("FAIL divu_zero got %h lat %0d want ffffffff lat 1",
                     r, lat); end
        checks++; if (busy !== 0 || spur !== 0) begin fails++;
            $display("FAIL divu_zero_busy got %0d/%0d want 0/0", busy, spur); end
        do_op(2'b10, 32'h1234, 0, 1'b0, r, lat, busy, spur);
        checks++; if (r !== 32'h1234 || lat !== 1 || busy !== 0) begin fails++;
            $display("FAIL remu_zero got %h lat %0d busy %0d want 1234 1 0",
                     r, lat, busy); end
        do_op(2'b11, 32'hDEAD, 32'hBEEF, 1'b0, r, lat, busy, spur);
        checks++; if (r !== 0 || lat !== 1 || busy !== 0) begin fails++;
            $display("FAIL reserved_op got %h lat %0d busy %0d want 0 1 0",
                     r, lat, busy); end
    endtask

    task automatic test_hold();
        int n;
        @(negedge clk);
        InValid = 1'b1; Op = 2'b01; OpA = 100; OpB = 7; OutReady = 1'b0;
        @(posedge clk); #1;
        InValid = 1'b0;
        n = 0;
        while (!OutValid && n < 100) begin @(posedge clk); #1; n++; end
        checks++; if (n !== 33) begin fails++;
            $display("FAIL hold_latency got %0d want 33", n); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            InValid = 1'b1; Op = 2'b00; OpA = 2; OpB = 3;
            @(posedge clk); #1;
            checks++;
            if (OutValid !== 1'b1 || Result !== 14 || InReady !== 1'b0) begin
                fails++;
                $display("FAIL hold[%0d] got v=%b r=%0d rdy=%b want 1 14 0",
                         i, OutValid, Result, InReady); end
        end
        @(negedge clk);
        OutReady = 1'b1;
        @(posedge clk); #1;
        OutReady = 1'b0;
        checks++;
        if (InReady !== 1'b1 || OutValid !== 1'b0 || AluBusy !== 1'b0) begin
            fails++;
            $display("FAIL hold_release got rdy=%b v=%b busy=%b want 1 0 0",
                     InReady, OutValid, AluBusy); end
        @(posedge clk); #1;
        InValid = 1'b0;
        checks++; if (InReady !== 1'b0) begin fails++;
            $display("FAIL hold_accept got rdy=%b want 0", InReady); end
        n = 0;
        while (!OutValid && n < 100) begin @(posedge clk); #1; n++; end
        checks++; if (n !== 33 || Result !== 6) begin fails++;
            $display("FAIL hold_next got lat %0d r %0d want 33 6", n, Result); end
        @(negedge clk);
        OutReady = 1'b1;
        @(posedge clk); #1;
        OutReady = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] r; int lat, busy, spur;
        @(negedge clk);
        InValid = 1'b1; Op = 2'b00; OpA = $urandom; OpB = $urandom;
        @(posedge clk); #1;
        InValid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (AluBusy !== 1'b1) begin fails++;
            $display("FAIL midrun_busy got %b want 1", AluBusy); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (InReady !== 1'b1 || OutValid !== 1'b0 || AluBusy !== 1'b0 ||
            AluOpA !== '0 || AluOpB !== '0) begin
            fails++;
            $display("FAIL midrun_reset got rdy=%b v=%b busy=%b a=%h b=%h",
                     InReady, OutValid, AluBusy, AluOpA, AluOpB); end
        @(negedge clk);
        reset = 1'b0;
        do_op(2'b00, 3, 4, 1'b0, r, lat, busy, spur);
        checks++; if (r !== 12 || lat !== 33) begin fails++;
            $display("FAIL midrun_mul3x4 got %0d lat %0d want 12 lat 33",
                     r, lat); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] r, a, b; int lat, busy, spur;
        for (int i = 0; i < 4; i++) begin
            a = $urandom; b = $urandom_range(1, 1000);
            do_op(2'(i % 3), a, b, 1'b1, r, lat, busy, spur);
            checks++;
            if (r !== model(2'(i % 3), a, b) || lat !== 33) begin fails++;
                $display("FAIL b2b[%0d] got %h lat %0d want %h lat 33",
                         i, r, lat, model(2'(i % 3), a, b)); end
            checks++; if (InReady !== 1'b1 || OutValid !== 1'b0) begin fails++;
                $display("FAIL b2b_idle[%0d] got rdy=%b v=%b want 1 0",
                         i, InReady, OutValid); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] r, a, b, exp; logic [1:0] op;
        int lat, busy, spur, elat, ebusy;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 0;
                1:       b = $urandom_range(1, 300);
                default: b = $urandom;
            endcase
            exp   = model(op, a, b);
            elat  = (op == 2'b11 || (op != 2'b00 && b == 0)) ? 1 : 33;
            ebusy = (elat == 33) ? 32 : 0;
            do_op(op, a, b, $urandom_range(0, 1) == 1, r, lat, busy, spur);
            checks++;
            if (r !== exp || lat !== elat || busy !== ebusy || spur !== 0) begin
                fails++;
                $display("FAIL rand[%0d] op%0d %h,%h got %h/%0d/%0d/%0d want %h/%0d/%0d/0",
                         i, op, a, b, r, lat, busy, spur, exp, elat, ebusy); end
        end
    endtask

    initial begin
        reset = 1'b1; InValid = 1'b0; Op = 2'b00;
        OpA = '0; OpB = '0; OutReady = 1'b0;
        test_reset();
        test_mul_basic();
        test_mul_wrap();
        test_divrem();
        test_div_zero();
        test_hold();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1, "timeout");
    end
endmodule
